// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - regfile write-port arbiter: pipeline writeback vs queued multdiv results (optional WB_BYPASS_EN)
module wb_port_arbiter #(
    parameter int DEPTH         = 4,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_exception,
    input  logic        md_is_div,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pending_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]       q_rd   [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] valid_next;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic [4:0]  eff_rd;
    logic [31:0] eff_data;
    logic        pipe_write;
    logic        not_empty;
    logic        head_live;
    logic        md_fire;
    logic        bypass;
    logic        pop;
    logic        push;

    // Exceptions redirect the result to $r30 carrying the unit-specific code.
    assign eff_rd     = md_exception ? 5'd30 : md_rd;
    assign eff_data   = md_exception ? (md_is_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE)) : md_data;
    assign pipe_write = pipe_we && (pipe_rd != 5'd0);
    assign not_empty  = (count != '0);
    assign head_live  = not_empty && q_valid[head];
    assign md_ready   = !reset && (count < CW'(DEPTH));
    assign md_fire    = md_valid && md_ready;

`ifdef WB_BYPASS_EN
    assign bypass = !reset && !not_empty && !pipe_write && md_valid && (eff_rd != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // A squashed head leaves without using the port, so it may pop under a pipeline write.
    assign pop  = not_empty && (!pipe_write || !q_valid[head]);
    // Results for $r0 or for a register the pipeline writes this cycle are accepted and dropped.
    assign push = md_fire && (eff_rd != 5'd0) && !bypass && !(pipe_write && (pipe_rd == eff_rd));

    // Write-port select: pipeline first, then bypass, then the live queue head.
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (reset) begin
            ctrl_writeEnable = 1'b0;
        end else if (pipe_write) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = pipe_rd;
            data_writeReg    = pipe_data;
        end else if (bypass) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = eff_rd;
            data_writeReg    = eff_data;
        end else if (head_live) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = q_rd[head];
            data_writeReg    = q_data[head];
        end
    end

    // Next valid bits: pop the head, squash WAW-hazarded entries, then mark the new tail.
    always_comb begin
        valid_next = q_valid;
        if (pop) begin
            valid_next[head] = 1'b0;
        end
        if (pipe_write) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_rd[i] == pipe_rd) begin
                    valid_next[i] = 1'b0;
                end
            end
        end
        if (push) begin
            valid_next[tail] = 1'b1;
        end
    end

    // Pending-destination mask from registered queue state only.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i]) begin
                pending_mask[q_rd[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    // Queue control state: pointers, occupancy and valid bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
        end else begin
            head    <= head + PW'(pop);
            tail    <= tail + PW'(push);
            count   <= count + CW'(push) - CW'(pop);
            q_valid <= valid_next;
        end
    end

    // Queue payload storage; meaningless unless the matching valid bit is set.
    always_ff @(posedge clock) begin
        if (push) begin
            q_rd[tail]   <= eff_rd;
            q_data[tail] <= eff_data;
        end
    end

endmodule
